// File: rtl/weighted_rr_fifo_arbiter.sv
// Four queued requesters drained onto one registered ready/valid port using
// weighted round-robin bursts; each queue may take up to weight+1 consecutive grants.
module weighted_rr_fifo_arbiter #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WW    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        wen,
   input  logic [DW-1:0]     a,
   input  logic [DW-1:0]     b,
   input  logic [DW-1:0]     c,
   input  logic [DW-1:0]     d,
   input  logic [4*WW-1:0]   weights,
   input  logic              out_ready,
   output logic [DW-1:0]     dout,
   output logic              valid,
   output logic [3:0]        full,
   output logic              err
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   logic [DW-1:0] mem_q    [4][DEPTH];
   logic [AW-1:0] wr_ptr_q [4];
   logic [AW-1:0] rd_ptr_q [4];
   logic [AW:0]   occ_q    [4];
   logic [AW:0]   occ_d    [4];
   logic [DW-1:0] wdata    [4];
   logic [WW-1:0] wsel     [4];
   logic [3:0]    full_q, nonempty, push, pop;
   logic          err_q, valid_q;
   logic [DW-1:0] dout_q;

   state_e        state_q, state_d;
   logic [1:0]    base_q, base_d, cur_q, cur_d;
   logic [WW:0]   cnt_q, cnt_d;
   logic [WW-1:0] wlat_q, wlat_d;
   logic          pop_en, pop_opp;
   logic [1:0]    pop_sel;
   logic [2:0]    hit_base, hit_next;

   // Returns {hit, index} of the first non-empty queue at start, start+1, ... (mod 4).
   function automatic logic [2:0] find_first(input logic [1:0] start, input logic [3:0] ne);
      logic [1:0] idx;
      find_first = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (ne[idx]) find_first = {1'b1, idx};
      end
   endfunction

   always_comb begin
      wdata[0] = a;
      wdata[1] = b;
      wdata[2] = c;
      wdata[3] = d;
      for (int i = 0; i < 4; i++) begin
         wsel[i]     = weights[i*WW +: WW];
         nonempty[i] = (occ_q[i] != '0);
      end
   end

   assign pop_opp  = ~valid_q | out_ready;
   assign hit_base = find_first(base_q, nonempty);
   assign hit_next = find_first(cur_q + 2'd1, nonempty);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      wlat_d  = wlat_q;
      pop_en  = 1'b0;
      pop_sel = cur_q;
      if (pop_opp) begin
         unique case (state_q)
            StIdle: begin
               if (hit_base[2]) begin
                  pop_en  = 1'b1;
                  pop_sel = hit_base[1:0];
                  cur_d   = hit_base[1:0];
                  cnt_d   = (WW+1)'(1);
                  wlat_d  = wsel[hit_base[1:0]];
                  state_d = StBurst;
               end
            end
            StBurst: begin
               if (nonempty[cur_q] && (cnt_q <= {1'b0, wlat_q})) begin
                  pop_en = 1'b1;
                  cnt_d  = cnt_q + (WW+1)'(1);
               end else if (hit_next[2]) begin
                  pop_en  = 1'b1;
                  pop_sel = hit_next[1:0];
                  cur_d   = hit_next[1:0];
                  cnt_d   = (WW+1)'(1);
                  wlat_d  = wsel[hit_next[1:0]];
               end else begin
                  state_d = StIdle;
                  base_d  = cur_q + 2'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Writes use the registered full flag, so a pop in the same cycle cannot rescue a drop.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         push[i]  = wen[i] & ~full_q[i];
         pop[i]   = pop_en & (pop_sel == 2'(i));
         occ_d[i] = occ_q[i];
         if (push[i] && !pop[i]) begin
            occ_d[i] = occ_q[i] + (AW+1)'(1);
         end else if (!push[i] && pop[i]) begin
            occ_d[i] = occ_q[i] - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= wdata[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            occ_q[i]    <= '0;
         end
         full_q  <= '0;
         err_q   <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         state_q <= StIdle;
         base_q  <= '0;
         cur_q   <= '0;
         cnt_q   <= '0;
         wlat_q  <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
            if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
            occ_q[i]  <= occ_d[i];
            full_q[i] <= (occ_d[i] == (AW+1)'(DEPTH));
         end
         err_q <= |(wen & full_q);
         if (pop_en) begin
            dout_q  <= mem_q[pop_sel][rd_ptr_q[pop_sel]];
            valid_q <= 1'b1;
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end
         state_q <= state_d;
         base_q  <= base_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         wlat_q  <= wlat_d;
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;
   assign full  = full_q;
   assign err   = err_q;

endmodule
